// File: rtl/wbuf_kernel_loader_if.sv
// Bus bundle between the kernel loader, its controller, the weight SRAM and the weight FIFO.
// The loader connects through the slave modport; the controller/SRAM/FIFO side uses master.
interface wbuf_kernel_loader_if #(
  parameter int DW   = 32,
  parameter int AW   = 16,
  parameter int CH_W = 10
);
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [CH_W-1:0] num_ch;
  logic            kern_req;
  logic            busy;
  logic            done;
  logic            sram_ren;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_rdata;
  logic            fifo_full;
  logic            fifo_wvalid;
  logic [DW-1:0]   fifo_wdata;
  logic            kern_last;

  modport slave (
    input  start, base_addr, num_ch, kern_req, sram_rdata, fifo_full,
    output busy, done, sram_ren, sram_addr, fifo_wvalid, fifo_wdata, kern_last
  );

  modport master (
    output start, base_addr, num_ch, kern_req, sram_rdata, fifo_full,
    input  busy, done, sram_ren, sram_addr, fifo_wvalid, fifo_wdata, kern_last
  );
endinterface

// File: rtl/wbuf_kernel_loader.sv
// Streams depthwise kernels from weight SRAM into the weight FIFO, one kernel per kern_req.
// SRAM returns are caught in a small skid buffer so fifo_full never loses or repeats a word.
//
//  state      | meaning
//  S_IDLE     | waiting for start
//  S_FETCH    | issuing the KK reads of the current kernel
//  S_DRAIN    | waiting for in-flight reads and skid to empty
//  S_WAIT_REQ | kernel delivered, waiting for downstream kern_req
//  S_DONE     | all kernels written; done pulse follows
module wbuf_kernel_loader #(
  parameter int DW     = 32,
  parameter int AW     = 16,
  parameter int KSIZE  = 3,
  parameter int RD_LAT = 1,
  parameter int CH_W   = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  wbuf_kernel_loader_if.slave  ldr_if
);
  localparam int KK = KSIZE * KSIZE;
  localparam int SD = RD_LAT + 1;
  localparam int IW = (KK > 1) ? $clog2(KK) : 1;
  localparam int PW = $clog2(SD);
  localparam int CW = $clog2(SD + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WAIT_REQ, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CH_W-1:0] ch_q, ch_d, nch_q, nch_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            req_q, req_d;
  logic            done_q;

  logic [RD_LAT-1:0] rd_pipe_q, last_pipe_q;
  logic [DW-1:0]     sk_data_q [SD];
  logic [SD-1:0]     sk_last_q;
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q;

  logic          ren, issue_ok, issue_last, push, pop, drained, last_kern, go_req;
  logic [CW-1:0] in_flight;

  assign push       = rd_pipe_q[RD_LAT-1];
  assign pop        = (cnt_q != '0) && !ldr_if.fifo_full;
  assign issue_last = (idx_q == IW'(KK - 1));
  assign drained    = (cnt_q == '0) && (rd_pipe_q == '0);
  assign last_kern  = ((ch_q + CH_W'(1)) == nch_q);
  assign go_req     = req_q || ldr_if.kern_req;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(rd_pipe_q[i]);
  end

  // A word popped this cycle frees its slot in time for a read issued now.
  assign issue_ok = (int'(cnt_q) + int'(in_flight) - int'(pop)) < SD;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    nch_d   = nch_q;
    idx_d   = idx_q;
    req_d   = req_q;
    ren     = 1'b0;
    if (state_q != S_IDLE && ldr_if.kern_req) req_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (ldr_if.start && !done_q) begin
          nch_d   = ldr_if.num_ch;
          addr_d  = ldr_if.base_addr;
          ch_d    = '0;
          idx_d   = '0;
          req_d   = 1'b0;
          state_d = (ldr_if.num_ch == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue_ok) begin
          ren    = 1'b1;
          addr_d = addr_q + AW'(1);
          if (issue_last) begin
            idx_d   = '0;
            state_d = S_DRAIN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drained) begin
          if (last_kern) begin
            state_d = S_DONE;
          end else if (go_req) begin
            state_d = S_FETCH;
            ch_d    = ch_q + CH_W'(1);
            req_d   = 1'b0;
          end else begin
            state_d = S_WAIT_REQ;
          end
        end
      end
      S_WAIT_REQ: begin
        if (go_req) begin
          state_d = S_FETCH;
          ch_d    = ch_q + CH_W'(1);
          req_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      ch_q        <= '0;
      nch_q       <= '0;
      idx_q       <= '0;
      req_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_pipe_q   <= '0;
      last_pipe_q <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      sk_last_q   <= '0;
      for (int i = 0; i < SD; i++) sk_data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      nch_q   <= nch_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      done_q  <= (state_q == S_DONE);
      // Each read carries its kern_last tag down the latency pipe alongside its valid bit.
      rd_pipe_q[0]   <= ren;
      last_pipe_q[0] <= ren && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i]   <= rd_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      if (push) begin
        sk_data_q[wp_q] <= ldr_if.sram_rdata;
        sk_last_q[wp_q] <= last_pipe_q[RD_LAT-1];
        wp_q            <= (wp_q == PW'(SD - 1)) ? '0 : wp_q + PW'(1);
      end
      if (pop) rp_q <= (rp_q == PW'(SD - 1)) ? '0 : rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign ldr_if.busy        = (state_q != S_IDLE) || done_q;
  assign ldr_if.done        = done_q;
  assign ldr_if.sram_ren    = ren;
  assign ldr_if.sram_addr   = addr_q;
  assign ldr_if.fifo_wvalid = pop;
  assign ldr_if.fifo_wdata  = sk_data_q[rp_q];
  assign ldr_if.kern_last   = pop && sk_last_q[rp_q];
endmodule

// File: tb/tb_wbuf_kernel_loader.sv
// Directed bench for wbuf_kernel_loader (KSIZE=3, RD_LAT=1) with a behavioural SRAM.
// Cycle 0 of each case is the cycle start is driven; all timing is relative to it.
module tb_wbuf_kernel_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wbuf_kernel_loader_if #(.DW(32), .AW(16), .CH_W(10)) ifc ();

  wbuf_kernel_loader #(.DW(32), .AW(16), .KSIZE(3), .RD_LAT(1), .CH_W(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ldr_if (ifc.slave)
  );

  function automatic logic [31:0] memf(input logic [15:0] a);
    memf = {a ^ 16'h5A5A, a};
  endfunction

  // One-cycle-latency SRAM; garbage when not read so stale sampling shows up.
  always @(posedge clk) begin
    if (ifc.sram_ren) ifc.sram_rdata <= memf(ifc.sram_addr);
    else              ifc.sram_rdata <= 32'hDEADBEEF;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          ren_cyc[$];
  logic [15:0] ren_adr[$];
  int          wr_cyc[$];
  logic [31:0] wr_dat[$];
  logic        wr_lst[$];
  int          done_cnt, done_cyc;
  logic        busy1;
  logic [63:0] snap;

  task automatic run_case(input logic [15:0] base, input int nch,
                          input int full_a, input int full_b, input int req_dly,
                          input int rq1, input int rq2, input int rq3,
                          input int rst_c, input int budget);
    int next_req;
    next_req = -1;
    ren_cyc.delete(); ren_adr.delete();
    wr_cyc.delete(); wr_dat.delete(); wr_lst.delete();
    done_cnt = 0; done_cyc = -1; busy1 = 1'b0; snap = '1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      ifc.start     = (c == 0);
      ifc.base_addr = base;
      ifc.num_ch    = 10'(nch);
      ifc.fifo_full = (c >= full_a) && (c <= full_b);
      ifc.kern_req  = (c == next_req) || (c == rq1) || (c == rq2) || (c == rq3);
      rst_n         = (c != rst_c);
      #1;
      if (ifc.sram_ren) begin
        ren_cyc.push_back(c);
        ren_adr.push_back(ifc.sram_addr);
      end
      if (ifc.fifo_wvalid) begin
        wr_cyc.push_back(c);
        wr_dat.push_back(ifc.fifo_wdata);
        wr_lst.push_back(ifc.kern_last);
        if (ifc.kern_last && req_dly > 0) next_req = c + req_dly;
      end
      if (ifc.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == 1) busy1 = ifc.busy;
      if (c == rst_c + 1)
        snap = {11'd0, ifc.busy, ifc.done, ifc.sram_ren, ifc.fifo_wvalid, ifc.kern_last,
                ifc.sram_addr, ifc.fifo_wdata};
      if (rst_c < 0 && done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    ifc.start = 1'b0; ifc.kern_req = 1'b0; ifc.fifo_full = 1'b0; rst_n = 1'b1;
  endtask

  task automatic chk_stream(input string tag, input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (i < ren_adr.size()) chk($sformatf("%s_addr%0d", tag, i), 64'(ren_adr[i]), 64'(a));
      if (i < wr_dat.size()) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(wr_dat[i]), 64'(memf(a)));
        chk($sformatf("%s_last%0d", tag, i), 64'(wr_lst[i]), 64'((i % 9) == 8));
      end
    end
  endtask

  initial begin
    int n_a, n_b;
    ifc.start = 1'b0; ifc.base_addr = '0; ifc.num_ch = '0;
    ifc.kern_req = 1'b0; ifc.fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {ifc.busy, ifc.done, ifc.sram_ren, ifc.fifo_wvalid, ifc.kern_last,
                       ifc.sram_addr, ifc.fifo_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: single kernel, no backpressure
    run_case(16'h0100, 1, -1, -1, 0, -1, -1, -1, -1, 60);
    chk("t1_busy_c1", 64'(busy1), 64'd1);
    chk("t1_nren", 64'(ren_cyc.size()), 64'd9);
    if (ren_cyc.size() == 9) begin
      chk("t1_ren_first", 64'(ren_cyc[0]), 64'd1);
      chk("t1_ren_last", 64'(ren_cyc[8]), 64'd9);
    end
    chk("t1_nwr", 64'(wr_cyc.size()), 64'd9);
    if (wr_cyc.size() == 9) begin
      chk("t1_wr_first", 64'(wr_cyc[0]), 64'd3);
      chk("t1_wr_last", 64'(wr_cyc[8]), 64'd11);
    end
    chk_stream("t1", 16'h0100, 9);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_done_cyc", 64'(done_cyc), 64'd14);

    // T2: three kernels, kern_req 5 cycles after each kern_last
    run_case(16'h0100, 3, -1, -1, 5, -1, -1, -1, -1, 90);
    chk("t2_nren", 64'(ren_cyc.size()), 64'd27);
    chk("t2_nwr", 64'(wr_cyc.size()), 64'd27);
    chk_stream("t2", 16'h0100, 27);
    if (wr_cyc.size() == 27) begin
      chk("t2_k1_first", 64'(wr_cyc[9]), 64'd19);
      chk("t2_k2_first", 64'(wr_cyc[18]), 64'd35);
    end
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_done_cyc", 64'(done_cyc), 64'd46);

    // T3: fifo_full high cycles 4..8
    run_case(16'h0100, 1, 4, 8, 0, -1, -1, -1, -1, 60);
    n_a = 0; n_b = 0;
    foreach (ren_cyc[i]) if (ren_cyc[i] >= 4 && ren_cyc[i] <= 8) n_a++;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= 4 && wr_cyc[i] <= 8) n_b++;
    chk("t3_ren_in_full", 64'(n_a), 64'd0);
    chk("t3_wr_in_full", 64'(n_b), 64'd0);
    chk("t3_nren", 64'(ren_cyc.size()), 64'd9);
    chk("t3_nwr", 64'(wr_cyc.size()), 64'd9);
    if (ren_cyc.size() == 9) begin
      chk("t3_ren2", 64'(ren_cyc[2]), 64'd3);
      chk("t3_ren3", 64'(ren_cyc[3]), 64'd9);
    end
    if (wr_cyc.size() == 9) chk("t3_wr1", 64'(wr_cyc[1]), 64'd9);
    chk_stream("t3", 16'h0100, 9);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);

    // T4: two early kern_req pulses count once; third kernel waits for a new one
    run_case(16'h0100, 3, -1, -1, 0, 3, 5, 40, -1, 100);
    chk("t4_nren", 64'(ren_cyc.size()), 64'd27);
    if (ren_cyc.size() == 27) begin
      chk("t4_k1_ren", 64'(ren_cyc[9]), 64'd13);
      chk("t4_k1_end", 64'(ren_cyc[17]), 64'd21);
      chk("t4_k2_ren", 64'(ren_cyc[18]), 64'd41);
    end
    chk("t4_nwr", 64'(wr_cyc.size()), 64'd27);
    chk_stream("t4", 16'h0100, 27);
    chk("t4_done_cnt", 64'(done_cnt), 64'd1);

    // T5: zero channels, then address wrap
    run_case(16'h0100, 0, -1, -1, 0, -1, -1, -1, -1, 20);
    chk("t5_done_cyc", 64'(done_cyc), 64'd2);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);
    chk("t5_nren", 64'(ren_cyc.size()), 64'd0);
    chk("t5_nwr", 64'(wr_cyc.size()), 64'd0);
    run_case(16'hFFFC, 1, -1, -1, 0, -1, -1, -1, -1, 60);
    chk("t5w_nren", 64'(ren_cyc.size()), 64'd9);
    chk_stream("t5w", 16'hFFFC, 9);
    if (ren_adr.size() == 9) chk("t5w_addr_end", 64'(ren_adr[8]), 64'h0004);

    // T6: reset in cycle 6 of a T1 run, then a clean rerun
    run_case(16'h0100, 1, -1, -1, 0, -1, -1, -1, 6, 30);
    chk("t6_outs_after_rst", snap, 64'd0);
    n_a = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] > 6) n_a++;
    chk("t6_wr_after_rst", 64'(n_a), 64'd0);
    chk("t6_nwr", 64'(wr_cyc.size()), 64'd4);
    chk("t6_done_cnt", 64'(done_cnt), 64'd0);
    run_case(16'h0100, 1, -1, -1, 0, -1, -1, -1, -1, 60);
    chk("t6b_nwr", 64'(wr_cyc.size()), 64'd9);
    chk_stream("t6b", 16'h0100, 9);
    chk("t6b_done_cyc", 64'(done_cyc), 64'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
